// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC, credit-limited imem requests, in-order response buffer and redirect drain.
// Optional FETCH_BYPASS_EN: a response into an empty buffer is forwarded to decode in the same cycle.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN} state_t;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W-1:0] r_tag_wptr;
    logic [PTR_W-1:0] r_tag_rptr;
    logic [31:0]      r_fifo_data [FIFO_DEPTH];
    logic [31:0]      r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]      r_tag       [FIFO_DEPTH];

    logic             w_req_hs;
    logic             w_resp_keep;
    logic             w_fifo_empty;
    logic             w_credit;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_out_nxt;
    logic [CNT_W-1:0] w_drop_nxt;
    logic [1:0]       w_unused_redirect_lsbs;

    assign w_unused_redirect_lsbs = redirect_pc[1:0];

    // Credit covers both in-flight requests and buffered entries so the buffer can never overflow.
    assign w_credit       = (SUM_W'(r_outstanding) + SUM_W'(r_count)) < SUM_W'(FIFO_DEPTH);
    assign imem_req_valid = (r_state == S_RUN) && w_credit && !redirect_valid;
    assign imem_req_addr  = r_pc;
    assign w_req_hs       = imem_req_valid && imem_req_ready;

    // Responses are stale while draining or when a redirect lands in the same cycle.
    assign w_resp_keep  = imem_resp_valid && !redirect_valid && (r_drop == '0);
    assign w_fifo_empty = (r_count == '0);
    assign w_out_nxt    = r_outstanding + CNT_W'(w_req_hs) - CNT_W'(imem_resp_valid);
    assign w_drop_nxt   = r_drop - CNT_W'(imem_resp_valid);

`ifdef FETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass    = w_fifo_empty && w_resp_keep;
    assign instr_valid = (!w_fifo_empty || w_bypass) && !redirect_valid;
    assign instr       = w_bypass ? imem_resp_data : r_fifo_data[r_rptr];
    assign instr_pc    = w_bypass ? r_tag[r_tag_rptr] : r_fifo_pc[r_rptr];
    assign w_push      = w_resp_keep && !(w_bypass && instr_ready);
    assign w_pop       = !w_fifo_empty && instr_valid && instr_ready;
`else
    assign instr_valid = !w_fifo_empty && !redirect_valid;
    assign instr       = r_fifo_data[r_rptr];
    assign instr_pc    = r_fifo_pc[r_rptr];
    assign w_push      = w_resp_keep;
    assign w_pop       = instr_valid && instr_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_tag_wptr    <= '0;
            r_tag_rptr    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
                r_tag[i]       <= '0;
            end
        end else begin
            r_outstanding <= w_out_nxt;

            // Tag queue tracks every in-flight request, including ones that will be dropped.
            if (w_req_hs) begin
                r_tag[r_tag_wptr] <= r_pc;
                r_tag_wptr        <= r_tag_wptr + PTR_W'(1);
            end
            if (imem_resp_valid) begin
                r_tag_rptr <= r_tag_rptr + PTR_W'(1);
            end

            if (redirect_valid) begin
                r_pc    <= {redirect_pc[31:2], 2'b00};
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_req_hs) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_push) begin
                    r_fifo_data[r_wptr] <= imem_resp_data;
                    r_fifo_pc[r_wptr]   <= r_tag[r_tag_rptr];
                    r_wptr              <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end

            case (r_state)
                S_BOOT: r_state <= S_RUN;
                S_RUN: begin
                    if (redirect_valid && (w_out_nxt != '0)) begin
                        r_drop  <= w_out_nxt;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_drop <= w_drop_nxt;
                    if (w_drop_nxt == '0) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: memory model, sequential-PC reference stream, decode monitor.
module tb_instr_fetch;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    typedef struct packed { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct packed { logic [31:0] addr; int due; } req_t;

    exp_t        exp_q[$];
    req_t        pend[$];
    logic [31:0] next_req_addr;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    int          n_hs  = 0;
    int          cyc   = 0;
    int          last_due = 0;
    int          mem_fixed_lat = 1;
    logic        mem_always_ready = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h401101B3;
            32'h4:   return 32'h0020E4B3;
            32'h8:   return 32'h00C3A0B3;
            default: return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out or unexpected event (t=%0t)", name, $time);
    endtask

    // Decode expects a sequential PC stream starting at the reset PC or the latest redirect target.
    task automatic model_restart(input logic [31:0] t);
        logic [31:0] a;
        a = {t[31:2], 2'b00};
        exp_q.delete();
        for (int i = 0; i < 128; i++) begin
            exp_q.push_back({a, mem_word(a)});
            a = a + 32'd4;
        end
        next_req_addr = {t[31:2], 2'b00};
    endtask

    // Instruction memory: random ready, in-order responses at least one cycle after acceptance.
    initial begin
        int   lat;
        int   due;
        req_t r;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                pend.delete();
                last_due        = 0;
                imem_resp_valid = 1'b0;
                imem_req_ready  = 1'b0;
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    r               = pend.pop_front();
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(r.addr);
                end else begin
                    imem_resp_valid = 1'b0;
                    imem_resp_data  = $urandom;
                end
                imem_req_ready = mem_always_ready ? 1'b1 : (($urandom % 4) != 0);
            end
            @(negedge clk);
            if (rst_n && imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, next_req_addr);
                next_req_addr = next_req_addr + 32'd4;
                n_hs++;
                lat = (mem_fixed_lat > 0) ? mem_fixed_lat : 1 + int'($urandom_range(0, 2));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back({imem_req_addr, due});
            end
        end
    end

    // Decode-side monitor: pops the reference stream on every accepted instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && redirect_valid) begin
                chk("valid_during_redirect", {31'h0, instr_valid}, 32'h0);
            end
            if (rst_n && instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_instr");
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_pc", instr_pc, e.pc);
                    chk("instr", instr, e.data);
                end
                n_acc++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t;
        int          hs0;
        int          acc0;
        logic        found;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;
        model_restart(RPC);

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);

        // Boot cycle, first request, first instruction latency
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("boot_no_req", {31'h0, imem_req_valid}, 32'h0);
        @(negedge clk);
        chk("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("first_req_addr", imem_req_addr, RPC);
        @(negedge clk);
        chk("first_instr_latency", {31'h0, instr_valid}, {31'h0, BYP});
        @(negedge clk);
        chk("first_instr_visible", {31'h0, instr_valid}, 32'h1);
        acc0 = n_acc;
        repeat (10) @(negedge clk);
        chk("stream_progress", {31'h0, (n_acc - acc0) >= 3}, 32'h1);

        // Asynchronous reset mid-stream, then back-pressure from decode
        @(posedge clk);
        #3 rst_n = 1'b0;
        model_restart(RPC);
        #1;
        chk("async_rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("async_rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        hs0 = n_hs;
        repeat (12) @(posedge clk);
        chk("stall_req_count", 32'(n_hs - hs0), 32'(DEPTH));
        #1 instr_ready = 1'b1;
        acc0 = n_acc;
        repeat (20) @(posedge clk);
        chk("stall_release", {31'h0, (n_acc - acc0) >= 6}, 32'h1);

        // Redirect right after a request is accepted; the stale response must be dropped
        mem_fixed_lat = 3;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) found = 1'b1;
        end
        if (!found) fail_now("wait_handshake");
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        model_restart(32'h0000_0203);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                found = 1'b1;
                chk("redirect_req_addr", imem_req_addr, 32'h0000_0200);
            end
        end
        if (!found) fail_now("wait_redirect_req");
        repeat (10) @(posedge clk);

        // Randomized traffic with redirects, memory stalls and decode stalls
        mem_fixed_lat    = 0;
        mem_always_ready = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            instr_ready = (($urandom % 4) != 0);
            if (($urandom % 30) == 0) begin
                t = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : ($urandom & 32'h0000_3FFF);
                redirect_valid = 1'b1;
                redirect_pc    = t;
                model_restart(t);
            end else begin
                redirect_valid = 1'b0;
            end
        end

        // Final steady stream must keep flowing
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        instr_ready      = 1'b1;
        mem_always_ready = 1'b1;
        mem_fixed_lat    = 1;
        repeat (10) @(posedge clk);
        acc0 = n_acc;
        repeat (60) @(posedge clk);
        chk("final_throughput", {31'h0, (n_acc - acc0) >= 25}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
